lgn_frame_loader: RTL

Upstream input stage for the logic-gate-network MNIST classifier. It assembles a 256-bit binarized image from a stream of 8-bit bytes with a start-of-frame marker and commits it atomically to a double-buffered output register. The gate network and popcount/arg-max stages therefore see a stable image while the next frame streams in. It also reports framing errors and counts committed frames.

---
 rtl/lgn_frame_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/lgn_frame_loader.sv
// Assembles a start-marked byte stream into an INPUTS-bit image and commits it atomically to out_x.
// Commit on the edge sampling the final byte (out_valid one-cycle pulse); no backpressure, one byte per valid cycle.
module lgn_frame_loader #(
    parameter int INPUTS = 256,
    parameter int BYTES  = INPUTS / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_start,
    output logic [INPUTS-1:0] out_x,
    output logic              out_valid,
    output logic              busy,
    output logic              err_framing,
    output logic [7:0]        frame_count
);

    localparam int SRW = INPUTS - 8;
    localparam int CW  = $clog2(BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state_q, state_d;
    logic [SRW-1:0]    sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [INPUTS-1:0] out_x_q, out_x_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic [7:0]        fc_q, fc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            out_x_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            fc_q        <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_x_q     <= out_x_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            fc_q        <= fc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        out_x_d     = out_x_q;
        out_valid_d = 1'b0;
        err_d       = err_q;
        fc_d        = fc_q;
        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    // Bytes without a start marker while idle are silently dropped.
                    if (in_start) begin
                        sr_d    = SRW'(in_data);
                        cnt_d   = CW'(1);
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (in_start) begin
                        // Restart: the partial frame is lost and this byte becomes byte 0.
                        sr_d  = SRW'(in_data);
                        cnt_d = CW'(1);
                        err_d = 1'b1;
                    end else if (cnt_q == LAST) begin
                        out_x_d     = {sr_q, in_data};
                        out_valid_d = 1'b1;
                        fc_d        = fc_q + 8'd1;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        sr_d  = {sr_q[SRW-9:0], in_data};
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign out_x       = out_x_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q == LOAD);
    assign err_framing = err_q;
    assign frame_count = fc_q;

endmodule
